softmax_backward: RTL and testbench
===================================

SOFTMAX_BACKWARD -- requirements
Module: softmax_backward

Interface
REQ-001 Parameter WIDTH, default 16, signed fixed-point word width of all data ports.
REQ-002 Parameter DIMENSION, default 10, number of vector elements.
REQ-003 Parameter FIXED_POINT_INDEX, default 8, fractional bit count (1.0 = 2^FIXED_POINT_INDEX).
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  request a gradient computation; sampled only in IDLE.
REQ-007 Port y_data  input  signed WIDTH x DIMENSION  softmax forward outputs y[i].
REQ-008 Port grad_in  input  signed WIDTH x DIMENSION  upstream gradient g[i].
REQ-009 Port grad_out  output  signed WIDTH x DIMENSION  input gradient dx[i], registered.
REQ-010 Port busy  output  1  high while state is DOT or SCALE.
REQ-011 Port done  output  1  registered one-cycle completion pulse.

Function
REQ-012 The block SHALL compute dx[i] = y[i] * (g[i] - S), where S = sum over j of y[j]*g[j].
REQ-013 FSM states: IDLE, DOT, SCALE, DONE.
REQ-014 IDLE, start=1 at an edge: latch y_data and grad_in into internal registers, clear accumulator, index := 0, go to DOT; later input changes have no effect.
REQ-015 DOT: one multiply-accumulate per edge, acc += y[idx]*g[idx] at full 2*WIDTH product precision; acc width >= 2*WIDTH+clog2(DIMENSION)+1; no intermediate rounding.
REQ-016 DOT, after the DIMENSION-th MAC: S_q := sat_WIDTH(acc >>> FIXED_POINT_INDEX), index := 0, go to SCALE.
REQ-017 SCALE: one element per edge; diff = g[idx] - S_q in WIDTH+1 bits; grad_out[idx] := sat_WIDTH((y[idx]*diff) >>> FIXED_POINT_INDEX).
REQ-018 Shifts SHALL be arithmetic (floor toward negative infinity); sat_WIDTH clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 SCALE, after element DIMENSION-1 is written: go to DONE and set done := 1 on that same edge.
REQ-020 DONE: done high for exactly one cycle; next edge done := 0, go to IDLE; start is ignored in DONE.
REQ-021 Latency: start sampled at edge k -> busy high for exactly 2*DIMENSION cycles after edge k; done high in the cycle following edge k+2*DIMENSION.
REQ-022 start asserted while busy or in DONE SHALL be ignored, with no effect on the running computation.
REQ-023 start held high continuously SHALL launch a new computation at the first edge spent in IDLE.
REQ-024 grad_out elements not yet rewritten SHALL hold their previous values during an operation; all elements are valid when done=1 and held until the next operation's SCALE.

Reset
REQ-025 reset=1 at an edge SHALL force state IDLE, busy=0, done=0, all grad_out elements = 0, accumulator and index = 0, overriding start.
REQ-026 Reset asserted mid-operation SHALL abort the operation without a done pulse; the next start after reset deasserts SHALL complete normally.

Verification (WIDTH=16, DIMENSION=10, FIXED_POINT_INDEX=8)
REQ-027 Nominal: y[0]=y[1]=128, other y=0; g[0]=256, other g=0 -> S_q=128, grad_out[0]=64, grad_out[1]=-64, others 0, done one cycle.
REQ-028 Latency: single-cycle start pulse -> busy high for exactly 20 cycles, then done high for exactly 1 cycle, then busy=done=0.
REQ-029 Saturation: y[0]=y[1]=32767, g[0]=32767, g[1]=-32768, rest 0 -> S_q=-128, grad_out[0]=32767, grad_out[1]=-32768.
REQ-030 Input isolation: change y_data/grad_in and pulse start during busy -> results equal the REQ-027 values, exactly one done pulse.
REQ-031 Reset mid-run: reset asserted for one cycle at cycle 15 after start -> next cycle busy=0, done=0, all grad_out=0; restart with REQ-027 stimulus reproduces REQ-027 results.
REQ-032 Back-to-back: start held high for 50 cycles -> done pulses spaced 22 cycles apart, each with correct results.

Source files
------------

// File: rtl/softmax_backward.sv
// Softmax backward pass: dx[i] = y[i] * (g[i] - sum_j y[j]*g[j]).
// Serial datapath, one MAC per cycle for the dot product then one element per cycle.
module softmax_backward #(
  parameter int WIDTH             = 16,
  parameter int DIMENSION         = 10,
  parameter int FIXED_POINT_INDEX = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DIMENSION-1:0][WIDTH-1:0]   y_data,
  input  logic [DIMENSION-1:0][WIDTH-1:0]   grad_in,
  output logic [DIMENSION-1:0][WIDTH-1:0]   grad_out,
  output logic                              busy,
  output logic                              done
);

  localparam int IW   = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam int ACCW = 2*WIDTH + IW + 1;
  localparam logic [IW-1:0] LAST = IW'(DIMENSION-1);

  localparam logic signed [ACCW-1:0] MAXV =
    {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV =
    {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, DOT, SCALE, DONE
  } state_t;

  state_t                            state_q;
  logic [IW-1:0]                     idx_q;
  logic signed [ACCW-1:0]            acc_q;
  logic signed [WIDTH-1:0]           s_q;
  logic [DIMENSION-1:0][WIDTH-1:0]   y_q;
  logic [DIMENSION-1:0][WIDTH-1:0]   g_q;
  logic [DIMENSION-1:0][WIDTH-1:0]   grad_q;
  logic                              done_q;

  logic signed [WIDTH-1:0]           y_e;
  logic signed [WIDTH-1:0]           g_e;
  logic signed [2*WIDTH-1:0]         prod;
  logic signed [ACCW-1:0]            acc_d;
  logic signed [WIDTH:0]             diff;
  logic signed [2*WIDTH:0]           sprod;

  function automatic logic [WIDTH-1:0] sat(
    input logic signed [ACCW-1:0] v
  );
    logic [WIDTH-1:0] r;
    if (v > MAXV)      r = MAXV[WIDTH-1:0];
    else if (v < MINV) r = MINV[WIDTH-1:0];
    else               r = v[WIDTH-1:0];
    return r;
  endfunction

  assign y_e   = $signed(y_q[idx_q]);
  assign g_e   = $signed(g_q[idx_q]);
  assign prod  = y_e * g_e;
  assign acc_d = acc_q + ACCW'(prod);
  // Difference kept one bit wider so g - S never wraps.
  assign diff  = {g_e[WIDTH-1], g_e} - {s_q[WIDTH-1], s_q};
  assign sprod = y_e * diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      grad_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            y_q     <= y_data;
            g_q     <= grad_in;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= DOT;
          end
        end
        DOT: begin
          acc_q <= acc_d;
          if (idx_q == LAST) begin
            s_q     <= sat(acc_d >>> FIXED_POINT_INDEX);
            idx_q   <= '0;
            state_q <= SCALE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SCALE: begin
          grad_q[idx_q] <= sat(ACCW'(sprod >>> FIXED_POINT_INDEX));
          if (idx_q == LAST) begin
            idx_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grad_out = grad_q;
  assign done     = done_q;
  assign busy     = (state_q == DOT) || (state_q == SCALE);

endmodule

// File: tb/tb_softmax_backward.sv
// Self-checking bench for softmax_backward: timeline reference model
// plus directed scenarios and randomized traffic.
module tb_softmax_backward;

  localparam int W = 16;
  localparam int D = 10;
  localparam int F = 8;

  typedef logic [D-1:0][W-1:0] vec_t;

  logic clk;
  logic reset;
  logic start;
  vec_t y_data;
  vec_t grad_in;
  vec_t grad_out;
  logic busy;
  logic done;

  softmax_backward #(
    .WIDTH(W),
    .DIMENSION(D),
    .FIXED_POINT_INDEX(F)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .y_data(y_data),
    .grad_in(grad_in),
    .grad_out(grad_out),
    .busy(busy),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact integers, floor shift, clamp.
  longint res_m[D];
  longint s_m;

  function automatic longint sat(input longint v);
    longint hi = (64'sd1 <<< (W-1)) - 1;
    longint lo = -(64'sd1 <<< (W-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic compute_model(input vec_t y, input vec_t g);
    longint acc = 0;
    longint yi, gi;
    for (int i = 0; i < D; i++) begin
      yi = longint'($signed(y[i]));
      gi = longint'($signed(g[i]));
      acc += yi * gi;
    end
    s_m = sat(acc >>> F);
    for (int i = 0; i < D; i++) begin
      yi = longint'($signed(y[i]));
      gi = longint'($signed(g[i]));
      res_m[i] = sat((yi * (gi - s_m)) >>> F);
    end
  endtask

  // Timeline model: an accepted start at edge k yields busy for
  // edges k..k+19, element i written at edge k+11+i, done after k+20,
  // and a new start can only be taken from edge k+22 on.
  int     cyc = 0;
  int     kst = 0;
  bit     active = 0;
  longint res_act[D];
  longint exp_go[D];
  bit     exp_busy = 0;
  bit     exp_done = 0;

  initial begin
    int n;
    bit was;
    for (int i = 0; i < D; i++) exp_go[i] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        active = 0;
        for (int i = 0; i < D; i++) exp_go[i] = 0;
      end else begin
        was = active;
        if (active) begin
          n = cyc - kst;
          if (n >= 11 && n <= 20) exp_go[n-11] = res_act[n-11];
          if (n >= 21) active = 0;
        end
        if (!was && start) begin
          kst = cyc;
          active = 1;
          compute_model(y_data, grad_in);
          res_act = res_m;
        end
      end
      n = cyc - kst;
      exp_busy = active && (n <= 19);
      exp_done = active && (n == 20);
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  int done_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cyc.push_back(cyc);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      for (int i = 0; i < D; i++)
        chk($sformatf("grad_out[%0d]", i),
            $signed(grad_out[i]), exp_go[i]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t rnd_vec(input bit isy);
    vec_t v;
    int m = $urandom_range(0, 3);
    for (int i = 0; i < D; i++) begin
      if (m == 0)   v[i] = W'($urandom);
      else if (isy) v[i] = W'($urandom_range(0, 256));
      else          v[i] = W'($urandom_range(0, 1023) - 512);
    end
    return v;
  endfunction

  task automatic run_op(input vec_t y, input vec_t g,
                        output int bcyc, output bit got);
    y_data  = y;
    grad_in = g;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcyc  = 0;
    got   = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy === 1'b1) bcyc++;
        @(negedge clk);
      end
    end
  endtask

  vec_t nom_y, nom_g, sat_y, sat_g;

  initial begin
    int  bc;
    bit  got;

    nom_y = '0; nom_g = '0;
    nom_y[0] = 16'd128; nom_y[1] = 16'd128; nom_g[0] = 16'd256;
    sat_y = '0; sat_g = '0;
    sat_y[0] = 16'h7fff; sat_y[1] = 16'h7fff;
    sat_g[0] = 16'h7fff; sat_g[1] = 16'h8000;

    reset = 1'b1; start = 1'b0; y_data = '0; grad_in = '0;

    // Pin the reference arithmetic with hand-worked values.
    compute_model(nom_y, nom_g);
    chk("model_nom_S", s_m, 128);
    chk("model_nom_dx0", res_m[0], 64);
    chk("model_nom_dx1", res_m[1], -64);
    chk("model_nom_dx2", res_m[2], 0);
    compute_model(sat_y, sat_g);
    chk("model_sat_S", s_m, -128);
    chk("model_sat_dx0", res_m[0], 32767);
    chk("model_sat_dx1", res_m[1], -32768);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grad", grad_out, 0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal result and latency.
    run_op(nom_y, nom_g, bc, got);
    chk("nom_got_done", got, 1);
    chk("nom_busy_cycles", bc, 20);
    chk("nom_dx0", $signed(grad_out[0]), 64);
    chk("nom_dx1", $signed(grad_out[1]), -64);
    chk("nom_dx5", $signed(grad_out[5]), 0);
    @(negedge clk);
    chk("nom_after_done", done, 0);
    chk("nom_after_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Saturation.
    run_op(sat_y, sat_g, bc, got);
    chk("sat_got_done", got, 1);
    chk("sat_dx0", $signed(grad_out[0]), 32767);
    chk("sat_dx1", $signed(grad_out[1]), -32768);
    repeat (3) @(negedge clk);

    // Input isolation while busy.
    done_cyc.delete();
    y_data = nom_y; grad_in = nom_g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    y_data = rnd_vec(1); grad_in = rnd_vec(0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      y_data = rnd_vec(1); grad_in = rnd_vec(0);
      @(negedge clk);
    end
    repeat (15) @(negedge clk);
    chk("iso_done_count", done_cyc.size(), 1);
    chk("iso_dx0", $signed(grad_out[0]), 64);
    chk("iso_dx1", $signed(grad_out[1]), -64);

    // Reset fifteen cycles into an operation.
    done_cyc.delete();
    y_data = nom_y; grad_in = sat_g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_grad", grad_out, 0);
    repeat (25) @(negedge clk);
    chk("mid_rst_no_done", done_cyc.size(), 0);
    run_op(nom_y, nom_g, bc, got);
    chk("restart_got_done", got, 1);
    chk("restart_busy_cycles", bc, 20);
    chk("restart_dx0", $signed(grad_out[0]), 64);
    chk("restart_dx1", $signed(grad_out[1]), -64);
    repeat (2) @(negedge clk);

    // Start held high: launches every 22 cycles.
    done_cyc.delete();
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      y_data = rnd_vec(1); grad_in = rnd_vec(0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("b2b_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("b2b_gap1", done_cyc[1] - done_cyc[0], 22);
      chk("b2b_gap2", done_cyc[2] - done_cyc[1], 22);
    end

    // Randomized traffic with sporadic starts and resets.
    for (int i = 0; i < 1500; i++) begin
      y_data  = rnd_vec(1);
      grad_in = rnd_vec(0);
      start   = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
